// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: state encoding, timeout code and default 50 MHz timing for the ultrasonic scheduler
package ultrasonic_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_e;
  localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
  localparam int DEF_TRIG_CYCLES   = 500;
  localparam int DEF_CYCLES_PER_CM = 2900;
  localparam int DEF_MAX_CM        = 400;
  localparam int DEF_RISE_TIMEOUT  = 50000;
  localparam int DEF_GAP_CYCLES    = 500000;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ultrasonic_scheduler_echo_sync.sv
// echo_sync: per-bit 2-flop synchroniser with async active-low clear
module echo_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo timing of N ultrasonic sensors, distance reported in cm
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS     = 4,
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int CYCLES_PER_CM = DEF_CYCLES_PER_CM,
  parameter int MAX_CM        = DEF_MAX_CM,
  parameter int RISE_TIMEOUT  = DEF_RISE_TIMEOUT,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  localparam int IW = N_SENSORS > 1 ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [N_SENSORS-1:0] sensor_mask_i,
  input  logic [N_SENSORS-1:0] echo_i,
  output logic [N_SENSORS-1:0] trigger_o,
  output logic [15:0]          dist_o,
  output logic [IW-1:0]        dist_id_o,
  output logic                 dist_valid_o,
  output logic                 timeout_o,
  output logic                 busy_o
);
  localparam int CW = $clog2(max_of(max_of(TRIG_CYCLES, RISE_TIMEOUT),
                                    max_of(GAP_CYCLES, CYCLES_PER_CM)) + 1);
  localparam int MW = $clog2(MAX_CM + 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, pre_q, pre_d;
  logic [MW-1:0]   cm_q, cm_d, cm_inc;
  logic [IW-1:0]   sel_q, sel_d, last_q, last_d, nxt, j;
  logic [15:0]     dist_q, dist_d;
  logic [IW-1:0]   id_q, id_d;
  logic            to_q, to_d, ed_q, es, rise, fall, found, pre_wrap;
  logic [N_SENSORS-1:0] echo_s;

  echo_sync #(.W(N_SENSORS)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (echo_i),
    .q_o   (echo_s)
  );

  assign es   = echo_s[sel_q];
  assign rise = es & ~ed_q;
  assign fall = ~es & ed_q;

  // first set mask bit strictly after the last-served index, wrapping
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    j     = last_q;
    for (int k = 0; k < N_SENSORS; k++) begin
      j = (j == IW'(N_SENSORS - 1)) ? '0 : j + 1'b1;
      if (!found && sensor_mask_i[j]) begin
        found = 1'b1;
        nxt   = j;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    cm_d     = cm_q;
    sel_d    = sel_q;
    last_d   = last_q;
    dist_d   = dist_q;
    id_d     = id_q;
    to_d     = to_q;
    pre_wrap = pre_q == CW'(CYCLES_PER_CM - 1);
    cm_inc   = (pre_wrap && cm_q != MW'(MAX_CM)) ? cm_q + 1'b1 : cm_q;
    case (state_q)
      IDLE: if (enable_i && |sensor_mask_i) state_d = SELECT;
      SELECT: begin
        state_d = found ? TRIG : IDLE;
        sel_d   = found ? nxt : sel_q;
        cnt_d   = '0;
      end
      TRIG: begin
        state_d = cnt_q == CW'(TRIG_CYCLES - 1) ? WAIT_RISE : TRIG;
        cnt_d   = cnt_q == CW'(TRIG_CYCLES - 1) ? '0 : cnt_q + 1'b1;
      end
      WAIT_RISE: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          pre_d   = '0;
          cm_d    = '0;
          state_d = MEASURE;
        end else if (cnt_q == CW'(RISE_TIMEOUT - 1)) begin
          dist_d  = DIST_TIMEOUT;
          id_d    = sel_q;
          to_d    = 1'b1;
          state_d = REPORT;
        end
      end
      MEASURE: begin
        // the current cycle is counted, so dist = floor(echo_cycles / CYCLES_PER_CM)
        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        cm_d  = cm_inc;
        if (cm_inc == MW'(MAX_CM) || fall) begin
          to_d    = cm_inc == MW'(MAX_CM);
          dist_d  = cm_inc == MW'(MAX_CM) ? DIST_TIMEOUT : 16'(cm_inc);
          id_d    = sel_q;
          state_d = REPORT;
        end
      end
      REPORT: begin
        last_d  = sel_q;
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = enable_i ? SELECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      cm_q    <= '0;
      sel_q   <= '0;
      last_q  <= IW'(N_SENSORS - 1);
      dist_q  <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
      ed_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      cm_q    <= cm_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      dist_q  <= dist_d;
      id_q    <= id_d;
      to_q    <= to_d;
      ed_q    <= es;
    end
  end

  always_comb begin
    trigger_o        = '0;
    trigger_o[sel_q] = state_q == TRIG;
  end
  assign dist_o       = dist_q;
  assign dist_id_o    = id_q;
  assign timeout_o    = to_q;
  assign dist_valid_o = state_q == REPORT;
  assign busy_o       = state_q != IDLE;
endmodule
